// File: rtl/pwrmgr_rst_resp.sv
// Reset-request responder: per-domain lc/sys release sequencing with stretch timers.
// Optional reset-info capture is enabled by defining PWRMGR_RST_RESP_INFO_EN.
//
// state       | meaning
// ST_HOLD     | lc and sys held in reset
// ST_LC_WAIT  | lc request dropped, stretching before lc release
// ST_LC_REL   | lc released, sys still held
// ST_SYS_WAIT | sys request dropped, stretching before sys release
// ST_SYS_REL  | lc and sys both released
module pwrmgr_rst_resp #(
  parameter int PowerDomains  = 2,
  parameter int StretchCycles = 4,
  parameter int NumRstReqs    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [PowerDomains-1:0] rst_lc_req_i,
  input  logic [PowerDomains-1:0] rst_sys_req_i,
  input  logic [1:0]              reset_cause_i,
  input  logic [NumRstReqs:0]     rstreqs_i,
  output logic [PowerDomains-1:0] rst_lc_src_no,
  output logic [PowerDomains-1:0] rst_sys_src_no,
  output logic                    busy_o,
  output logic [NumRstReqs:0]     info_o,
  output logic                    info_valid_o,
  input  logic                    info_clr_i
);

  localparam int CntW = $clog2(StretchCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(StretchCycles - 1);

  if (StretchCycles < 1) begin : g_bad_cfg
    $error("pwrmgr_rst_resp: StretchCycles must be >= 1");
  end

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_LC_WAIT  = 3'd1,
    ST_LC_REL   = 3'd2,
    ST_SYS_WAIT = 3'd3,
    ST_SYS_REL  = 3'd4
  } state_e;

  state_e                  r_state  [PowerDomains];
  state_e                  w_state_d[PowerDomains];
  logic [CntW-1:0]         r_cnt    [PowerDomains];
  logic [CntW-1:0]         w_cnt_d  [PowerDomains];
  logic [PowerDomains-1:0] r_lc, r_sys, w_lc_d, w_sys_d, w_wait_d;
  logic                    r_busy;

  function automatic logic f_lc_on(input state_e s);
    return (s == ST_LC_REL) || (s == ST_SYS_WAIT) || (s == ST_SYS_REL);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < PowerDomains; i++) begin
        r_state[i] <= ST_HOLD;
        r_cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < PowerDomains; i++) begin
        r_state[i] <= w_state_d[i];
        r_cnt[i]   <= w_cnt_d[i];
      end
    end
  end

  // Domain 0 is resolved first so the cascade can see its next lc level in the
  // same cycle: non-AON domains drop on the same edge as the AON domain.
  always_comb begin
    for (int i = 0; i < PowerDomains; i++) begin
      w_state_d[i] = ST_HOLD;
      w_cnt_d[i]   = '0;
    end
    for (int i = 0; i < PowerDomains; i++) begin
      if (rst_lc_req_i[i] || ((i != 0) && !f_lc_on(w_state_d[0]))) begin
        w_state_d[i] = ST_HOLD;
      end else begin
        case (r_state[i])
          ST_HOLD:     w_state_d[i] = ((i == 0) || r_lc[0]) ? ST_LC_WAIT : ST_HOLD;
          ST_LC_WAIT:  w_state_d[i] = (r_cnt[i] == CntLast) ? ST_LC_REL : ST_LC_WAIT;
          ST_LC_REL:   w_state_d[i] = rst_sys_req_i[i] ? ST_LC_REL : ST_SYS_WAIT;
          ST_SYS_WAIT: w_state_d[i] = rst_sys_req_i[i] ? ST_LC_REL :
                                      (r_cnt[i] == CntLast) ? ST_SYS_REL : ST_SYS_WAIT;
          ST_SYS_REL:  w_state_d[i] = rst_sys_req_i[i] ? ST_LC_REL : ST_SYS_REL;
          default:     w_state_d[i] = ST_HOLD;
        endcase
      end
      if ((w_state_d[i] == r_state[i]) &&
          ((r_state[i] == ST_LC_WAIT) || (r_state[i] == ST_SYS_WAIT))) begin
        w_cnt_d[i] = r_cnt[i] + CntW'(1);
      end
    end
  end

  always_comb begin
    w_lc_d   = '0;
    w_sys_d  = '0;
    w_wait_d = '0;
    for (int i = 0; i < PowerDomains; i++) begin
      w_lc_d[i]   = f_lc_on(w_state_d[i]);
      w_sys_d[i]  = (w_state_d[i] == ST_SYS_REL);
      w_wait_d[i] = (w_state_d[i] == ST_LC_WAIT) || (w_state_d[i] == ST_SYS_WAIT);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_lc   <= '0;
      r_sys  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_lc   <= w_lc_d;
      r_sys  <= w_sys_d;
      r_busy <= |w_wait_d;
    end
  end

  assign rst_lc_src_no  = r_lc;
  assign rst_sys_src_no = r_sys;
  assign busy_o         = r_busy;

`ifdef PWRMGR_RST_RESP_INFO_EN
  localparam logic [1:0] CauseHwReq = 2'd2;

  logic [NumRstReqs:0] r_info;
  logic                r_info_valid;
  logic                w_capture;

  assign w_capture = (w_lc_d == '0) && (r_lc != '0) && (reset_cause_i == CauseHwReq);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_info       <= '0;
      r_info_valid <= 1'b0;
    end else if (w_capture) begin
      r_info       <= info_clr_i ? rstreqs_i : (r_info | rstreqs_i);
      r_info_valid <= 1'b1;
    end else if (info_clr_i) begin
      r_info       <= '0;
      r_info_valid <= 1'b0;
    end
  end

  assign info_o       = r_info;
  assign info_valid_o = r_info_valid;
`else
  logic w_unused_info;
  assign w_unused_info = ^{info_clr_i, reset_cause_i, rstreqs_i};
  assign info_o        = '0;
  assign info_valid_o  = 1'b0;
`endif

endmodule
